// File: rtl/rc4_phase_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : rc4_phase_sequencer_if
// Brief    : Control, per-phase handshake and shared-memory port bundle.
// Revision : 1.0
// ============================================================================
interface rc4_phase_sequencer_if #(
  parameter int NUM_PHASES = 3,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8
);
  logic                         start_i;
  logic                         abort_i;
  logic [NUM_PHASES-1:0]        phase_enable_i;
  logic                         finish_o;
  logic                         busy_o;
  logic                         timeout_error_o;
  logic [2:0]                   active_phase_o;
  logic [NUM_PHASES-1:0]        start_phase_o;
  logic [NUM_PHASES-1:0]        finish_phase_i;
  logic [NUM_PHASES-1:0]        write_enable_phase_i;
  logic [NUM_PHASES*ADDR_W-1:0] address_phase_i;
  logic [NUM_PHASES*DATA_W-1:0] write_data_phase_i;
  logic                         write_enable_out_o;
  logic [ADDR_W-1:0]            address_out_o;
  logic [DATA_W-1:0]            write_data_out_o;

  modport slave (
    input  start_i, abort_i, phase_enable_i, finish_phase_i,
           write_enable_phase_i, address_phase_i, write_data_phase_i,
    output finish_o, busy_o, timeout_error_o, active_phase_o, start_phase_o,
           write_enable_out_o, address_out_o, write_data_out_o
  );

  modport master (
    output start_i, abort_i, phase_enable_i, finish_phase_i,
           write_enable_phase_i, address_phase_i, write_data_phase_i,
    input  finish_o, busy_o, timeout_error_o, active_phase_o, start_phase_o,
           write_enable_out_o, address_out_o, write_data_out_o
  );
endinterface
`default_nettype wire

// File: rtl/rc4_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rc4_phase_sequencer
// Brief    : Runs enabled sub-FSM phases in index order, muxing the shared port.
// Revision : 1.0
// ============================================================================
module rc4_phase_sequencer #(
  parameter int NUM_PHASES     = 3,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic             clk,
  input  wire logic             reset,
  rc4_phase_sequencer_if.slave  bus
);

  localparam int c_IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit c_WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = {c_CNT_W{1'b1}};
  localparam logic [c_CNT_W-1:0] c_TO_LAST =
      (TIMEOUT_CYCLES > 0) ? c_CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [2:0] c_S_IDLE    = 3'd0;
  localparam logic [2:0] c_S_LAUNCH  = 3'd1;
  localparam logic [2:0] c_S_WAIT    = 3'd2;
  localparam logic [2:0] c_S_ADVANCE = 3'd3;
  localparam logic [2:0] c_S_DONE    = 3'd4;
  localparam logic [2:0] c_S_ERROR   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [NUM_PHASES-1:0] mask_q,  mask_d;
  logic [c_IDX_W-1:0]    idx_q,   idx_d;
  logic [c_CNT_W-1:0]    cnt_q,   cnt_d;
  logic                  terr_q,  terr_d;

  logic [ADDR_W-1:0]     w_addr [NUM_PHASES];
  logic [DATA_W-1:0]     w_data [NUM_PHASES];
  logic [c_IDX_W:0]      w_first;
  logic [c_IDX_W:0]      w_next;
  logic                  w_fin_act;
  logic                  w_mem_en;
  logic [2:0]            w_act;
  logic [NUM_PHASES-1:0] w_start;

  // Returns {found, index} of the lowest set bit of m at position lo or above.
  function automatic logic [c_IDX_W:0] f_find(input logic [NUM_PHASES-1:0] m,
                                              input int lo);
    logic [c_IDX_W:0] r;
    r = '0;
    for (int i = NUM_PHASES - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = {1'b1, c_IDX_W'(i)};
    end
    return r;
  endfunction

  generate
    for (genvar g = 0; g < NUM_PHASES; g++) begin : g_unpack
      assign w_addr[g] = bus.address_phase_i[g*ADDR_W +: ADDR_W];
      assign w_data[g] = bus.write_data_phase_i[g*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_first   = f_find(bus.phase_enable_i, 0);
  assign w_next    = f_find(mask_q, int'(idx_q) + 1);
  assign w_fin_act = bus.finish_phase_i[idx_q];

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    case (state_q)
      c_S_IDLE: begin
        if (bus.start_i) begin
          mask_d = bus.phase_enable_i;
          if (w_first[c_IDX_W]) begin
            idx_d   = w_first[c_IDX_W-1:0];
            state_d = c_S_LAUNCH;
          end else begin
            idx_d   = '0;
            state_d = c_S_DONE;
          end
        end
      end
      c_S_LAUNCH: state_d = c_S_WAIT;
      c_S_WAIT: begin
        if (cnt_q != c_CNT_MAX) cnt_d = cnt_q + 1'b1;
        // A finish landing on the last watchdog cycle still counts as success.
        if (w_fin_act) begin
          state_d = c_S_ADVANCE;
        end else if (c_WDOG_EN && (cnt_q == c_TO_LAST)) begin
          state_d = c_S_ERROR;
          terr_d  = 1'b1;
        end
      end
      c_S_ADVANCE: begin
        cnt_d = '0;
        if (w_next[c_IDX_W]) begin
          idx_d   = w_next[c_IDX_W-1:0];
          state_d = c_S_LAUNCH;
        end else begin
          idx_d   = '0;
          state_d = c_S_DONE;
        end
      end
      c_S_DONE: begin
        if (!bus.start_i) state_d = c_S_IDLE;
      end
      c_S_ERROR: terr_d = 1'b1;
      default:   state_d = c_S_IDLE;
    endcase

    if (bus.abort_i) begin
      state_d = c_S_IDLE;
      mask_d  = '0;
      idx_d   = '0;
      cnt_d   = '0;
      terr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= c_S_IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    w_act = '0;
    w_act[c_IDX_W-1:0] = idx_q;
  end

  // Abort suppresses a launch pulse that would otherwise fire this cycle.
  always_comb begin
    w_start = '0;
    if ((state_q == c_S_LAUNCH) && !bus.abort_i) w_start[idx_q] = 1'b1;
  end

  assign w_mem_en = (state_q == c_S_LAUNCH) || (state_q == c_S_WAIT);

  assign bus.finish_o           = (state_q == c_S_DONE);
  assign bus.busy_o             = (state_q == c_S_LAUNCH) || (state_q == c_S_WAIT) ||
                                  (state_q == c_S_ADVANCE);
  assign bus.timeout_error_o    = terr_q;
  assign bus.active_phase_o     = w_act;
  assign bus.start_phase_o      = w_start;
  assign bus.write_enable_out_o = w_mem_en & bus.write_enable_phase_i[idx_q];
  assign bus.address_out_o      = w_mem_en ? w_addr[idx_q] : '0;
  assign bus.write_data_out_o   = w_mem_en ? w_data[idx_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_rc4_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc4_phase_sequencer
// Brief    : Directed + randomized bench with a timeline model of phase runs.
// Revision : 1.0
// ============================================================================
module tb_rc4_phase_sequencer;
  localparam int NP = 3;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rc4_phase_sequencer_if #(.NUM_PHASES(NP), .ADDR_W(AW), .DATA_W(DW)) ifc ();

  rc4_phase_sequencer #(
    .NUM_PHASES(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run_ph = -1;
  int since = 0;
  int dly [NP];
  logic exp_err = 1'b0;
  logic [NP-1:0] cur_mask = '0;
  int pc_q [$];
  int pi_q [$];
  int pv_q [$];
  logic dir_en = 1'b0;
  logic [NP-1:0] dir_we = '0;
  logic [NP*AW-1:0] dir_addr = '0;
  logic [NP*DW-1:0] dir_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance phase responders, drive stimulus, check the memory port.
  task automatic tick();
    logic [NP-1:0] fin;
    logic [31:0] ew, ea, ed;
    @(posedge clk);
    #1;
    cyc++;
    if (run_ph >= 0) begin
      since++;
      if (dly[run_ph] <= TO && since == dly[run_ph] + 1) begin
        run_ph = -1;
      end else if (dly[run_ph] > TO && since == TO + 1) begin
        exp_err = 1'b1;
        run_ph = -1;
      end
    end
    fin = '0;
    if (run_ph >= 0 && since == dly[run_ph]) fin[run_ph] = 1'b1;
    if (ifc.start_phase_o != '0) begin
      pc_q.push_back(cyc);
      pi_q.push_back(int'(ifc.active_phase_o));
      pv_q.push_back(int'(ifc.start_phase_o));
      for (int i = 0; i < NP; i++) if (ifc.start_phase_o[i]) run_ph = i;
      since = 0;
    end
    ifc.finish_phase_i = fin | (NP'($urandom) & ~cur_mask);
    if (dir_en) begin
      ifc.write_enable_phase_i = dir_we;
      ifc.address_phase_i      = dir_addr;
      ifc.write_data_phase_i   = dir_data;
    end else begin
      ifc.write_enable_phase_i = NP'($urandom);
      for (int i = 0; i < NP; i++) begin
        ifc.address_phase_i[i*AW +: AW]    = AW'($urandom);
        ifc.write_data_phase_i[i*DW +: DW] = DW'($urandom);
      end
    end
    #1;
    ew = '0; ea = '0; ed = '0;
    if (run_ph >= 0) begin
      ew = 32'(ifc.write_enable_phase_i[run_ph]);
      ea = 32'(ifc.address_phase_i[run_ph*AW +: AW]);
      ed = 32'(ifc.write_data_phase_i[run_ph*DW +: DW]);
    end
    chk("mem_we", 32'(ifc.write_enable_out_o), ew);
    chk("mem_addr", 32'(ifc.address_out_o), ea);
    chk("mem_data", 32'(ifc.write_data_out_o), ed);
    chk("timeout_error", 32'(ifc.timeout_error_o), 32'(exp_err));
  endtask

  // Expected launch times: phases launch back to back, each occupying delay+2 cycles.
  task automatic run_seq(input logic [NP-1:0] m, input string tag);
    int t, tdone, k;
    int ec [$];
    int ei [$];
    pc_q.delete(); pi_q.delete(); pv_q.delete();
    cur_mask = m;
    ifc.phase_enable_i = m;
    ifc.start_i = 1'b1;
    t = cyc + 1;
    k = 0;
    for (int i = 0; i < NP; i++) begin
      if (m[i]) begin
        ec.push_back(t);
        ei.push_back(i);
        t = t + dly[i] + 2;
        k++;
      end
    end
    tdone = (k == 0) ? cyc + 1 : t;
    while (cyc < tdone - 1) tick();
    chk({tag, "_finish_early"}, 32'(ifc.finish_o), 0);
    tick();
    chk({tag, "_finish"}, 32'(ifc.finish_o), 1);
    chk({tag, "_busy_done"}, 32'(ifc.busy_o), 0);
    chk({tag, "_pulse_count"}, pc_q.size(), ec.size());
    for (int j = 0; j < ec.size() && j < pc_q.size(); j++) begin
      chk({tag, "_pulse_cycle"}, pc_q[j], ec[j]);
      chk({tag, "_pulse_active"}, pi_q[j], ei[j]);
      chk({tag, "_pulse_vec"}, pv_q[j], 1 << ei[j]);
    end
    ifc.phase_enable_i = NP'($urandom);
    tick();
    tick();
    chk({tag, "_finish_held"}, 32'(ifc.finish_o), 1);
    ifc.start_i = 1'b0;
    tick();
    chk({tag, "_finish_drop"}, 32'(ifc.finish_o), 0);
    chk({tag, "_busy_idle"}, 32'(ifc.busy_o), 0);
    chk({tag, "_active_idle"}, 32'(ifc.active_phase_o), 0);
    tick();
  endtask

  initial begin
    int t1;
    ifc.start_i = 1'b0;
    ifc.abort_i = 1'b0;
    ifc.phase_enable_i = '0;
    ifc.finish_phase_i = '0;
    ifc.write_enable_phase_i = '0;
    ifc.address_phase_i = '0;
    ifc.write_data_phase_i = '0;
    for (int i = 0; i < NP; i++) dly[i] = 5;

    tick();
    tick();
    chk("rst_finish", 32'(ifc.finish_o), 0);
    chk("rst_busy", 32'(ifc.busy_o), 0);
    chk("rst_active", 32'(ifc.active_phase_o), 0);
    chk("rst_start_phase", 32'(ifc.start_phase_o), 0);
    reset = 1'b1;
    tick();

    run_seq(3'b111, "all3");

    dir_en = 1'b1;
    dir_we = 3'b011;
    dir_addr = {8'h00, 8'hFF, 8'h3C};
    dir_data = {8'h00, 8'h00, 8'h3C};
    dly[0] = 4;
    run_seq(3'b001, "mux_p0");

    dir_we = 3'b111;
    dir_addr = {8'h5A, 8'hAA, 8'h11};
    dir_data = {8'h66, 8'h77, 8'h22};
    dly[0] = 3; dly[2] = 2;
    run_seq(3'b101, "skip1");
    dir_en = 1'b0;

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NP; i++) dly[i] = $urandom_range(1, 6);
      run_seq(NP'($urandom), "rand");
    end

    dly[1] = TO;
    run_seq(3'b010, "finish_at_timeout");

    dly[0] = 2; dly[1] = 1000;
    pc_q.delete(); pi_q.delete(); pv_q.delete();
    cur_mask = 3'b011;
    ifc.phase_enable_i = 3'b011;
    ifc.start_i = 1'b1;
    t1 = cyc + 1 + dly[0] + 2;
    while (cyc < t1 + TO) tick();
    chk("to_busy_before", 32'(ifc.busy_o), 1);
    tick();
    chk("to_error", 32'(ifc.timeout_error_o), 1);
    chk("to_finish", 32'(ifc.finish_o), 0);
    chk("to_busy", 32'(ifc.busy_o), 0);
    chk("to_pulses", pc_q.size(), 2);
    ifc.start_i = 1'b0;
    tick(); tick(); tick();
    chk("to_sticky", 32'(ifc.timeout_error_o), 1);
    ifc.abort_i = 1'b1;
    exp_err = 1'b0;
    tick();
    ifc.abort_i = 1'b0;
    chk("to_abort_busy", 32'(ifc.busy_o), 0);
    chk("to_abort_finish", 32'(ifc.finish_o), 0);
    tick();

    for (int i = 0; i < NP; i++) dly[i] = 5;
    pc_q.delete(); pi_q.delete(); pv_q.delete();
    cur_mask = 3'b111;
    ifc.phase_enable_i = 3'b111;
    ifc.start_i = 1'b1;
    for (int n = 0; n < 60 && pc_q.size() < 2; n++) tick();
    chk("abort_reach_p1", pc_q.size(), 2);
    tick();
    tick();
    ifc.abort_i = 1'b1;
    ifc.start_i = 1'b0;
    run_ph = -1;
    tick();
    chk("abort_busy", 32'(ifc.busy_o), 0);
    chk("abort_finish", 32'(ifc.finish_o), 0);
    chk("abort_start_phase", 32'(ifc.start_phase_o), 0);
    chk("abort_active", 32'(ifc.active_phase_o), 0);
    ifc.abort_i = 1'b0;
    tick();
    run_seq(3'b111, "replay");

    ifc.phase_enable_i = 3'b111;
    ifc.start_i = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    reset = 1'b0;
    ifc.start_i = 1'b0;
    run_ph = -1;
    tick();
    chk("midrst_finish", 32'(ifc.finish_o), 0);
    chk("midrst_busy", 32'(ifc.busy_o), 0);
    chk("midrst_active", 32'(ifc.active_phase_o), 0);
    chk("midrst_start_phase", 32'(ifc.start_phase_o), 0);
    reset = 1'b1;
    tick();

    run_seq(3'b000, "empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
